// File: rtl/lfsr_pkg.sv
// Shared types and the width-generic single-step helper
// for the LFSR pseudo-random word stream.
package lfsr_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic {
    FIBONACCI = 1'b0,
    GALOIS    = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_e;

  typedef logic [MAX_W-1:0] word_t;

  function automatic word_t lfsr_mask(
    input int unsigned width
  );
    return {MAX_W{1'b1}} >> (MAX_W - width);
  endfunction

  // Operands are zero-extended to MAX_W; result is
  // trimmed back to the live width.
  function automatic word_t lfsr_step_f(
    input mode_e       mode,
    input word_t       state,
    input word_t       taps,
    input int unsigned width
  );
    word_t mask;
    word_t nxt;
    mask = lfsr_mask(width);
    unique case (mode)
      FIBONACCI: begin
        nxt = {state[MAX_W-2:0],
               ^(state & taps & mask)};
      end
      GALOIS: begin
        nxt = (state >> 1)
            ^ (state[0] ? taps : '0);
      end
      default: nxt = state;
    endcase
    return nxt & mask;
  endfunction

endpackage

// File: rtl/lfsr_prng_stream_step.sv
// Combinational single LFSR step; chained OUT_W
// times by the stream top.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
  input  mode_e            mode_i,
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] next_o
);

  localparam int unsigned W_U = WIDTH;

  word_t nxt_w;
  logic  unused_hi;

  always_comb begin
    nxt_w = lfsr_step_f(mode_i,
                        MAX_W'(state_i),
                        MAX_W'(TAPS),
                        W_U);
  end

  assign next_o    = nxt_w[WIDTH-1:0];
  assign unused_hi = |(nxt_w >> WIDTH);

endmodule

// File: rtl/lfsr_prng_stream.sv
// Parametrised LFSR word generator: Fibonacci/Galois,
// seed load with lock-up guard, valid/ready output.
module lfsr_prng_stream
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter longint unsigned  SEED  = 1,
  parameter int               OUT_W = 8,
  parameter int               CNT_W = 32
) (
  input  logic             clk,
  input  logic             preset_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             mode_in,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_cnt,
  output logic             wrap,
  output logic             lockup_err
);

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("lfsr_prng_stream: WIDTH out of 2..64");
  end

  if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_outw
    $error("lfsr_prng_stream: OUT_W out of 1..WIDTH");
  end

  if (SEED == 0) begin : g_zero_seed
    $error("lfsr_prng_stream: SEED must be nonzero");
  end

  if ((SEED >> WIDTH) != 0) begin : g_wide_seed
    $error("lfsr_prng_stream: SEED wider than WIDTH");
  end

  localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);

  fsm_e             fsm_q, fsm_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] ref_seed_q, ref_seed_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;

  logic             hs;
  logic [WIDTH-1:0] seed_eff;
  logic [WIDTH-1:0] adv;

  logic [OUT_W:0][WIDTH-1:0] chain;

  assign chain[0] = state_q;

  for (genvar g = 0; g < OUT_W; g++) begin : g_chain
    lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
    ) u_step (
      .mode_i  (mode_q),
      .state_i (chain[g]),
      .next_o  (chain[g+1])
    );
  end

  assign adv = chain[OUT_W];

  always_comb begin
    hs         = (fsm_q == RUN) && out_ready;
    seed_eff   = (seed_in == '0) ? SEED_V : seed_in;
    fsm_d      = fsm_q;
    mode_d     = mode_q;
    state_d    = state_q;
    ref_seed_d = ref_seed_q;
    word_cnt_d = word_cnt_q;
    wrap_d     = 1'b0;
    lockup_d   = 1'b0;

    // A presented word stays until it is taken.
    unique case (fsm_q)
      IDLE: if (en) fsm_d = RUN;
      RUN:  if (hs && !en) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase

    if (hs) begin
      state_d = adv;
      wrap_d  = (adv == ref_seed_q);
      if (!(&word_cnt_q)) begin
        word_cnt_d = word_cnt_q + CNT_W'(1);
      end
    end

    // Load overrides the advance and count.
    if (load) begin
      state_d    = seed_eff;
      ref_seed_d = seed_eff;
      mode_d     = mode_e'(mode_in);
      word_cnt_d = '0;
      wrap_d     = 1'b0;
      lockup_d   = (seed_in == '0);
    end
  end

  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      fsm_q      <= IDLE;
      mode_q     <= GALOIS;
      state_q    <= SEED_V;
      ref_seed_q <= SEED_V;
      word_cnt_q <= '0;
      wrap_q     <= 1'b0;
      lockup_q   <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      mode_q     <= mode_d;
      state_q    <= state_d;
      ref_seed_q <= ref_seed_d;
      word_cnt_q <= word_cnt_d;
      wrap_q     <= wrap_d;
      lockup_q   <= lockup_d;
    end
  end

  assign out_data   = state_q[OUT_W-1:0];
  assign out_valid  = (fsm_q == RUN);
  assign word_cnt   = word_cnt_q;
  assign wrap       = wrap_q;
  assign lockup_err = lockup_q;

endmodule

// File: tb/tb_lfsr_prng_stream.sv
// Bench for lfsr_prng_stream: a 4-bit OUT_W=1 instance
// and the default 16-bit OUT_W=8 instance.
module tb_lfsr_prng_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        s_en, s_load, s_mode, s_ready;
  logic        s_valid, s_wrap, s_lock;
  logic [3:0]  s_seed;
  logic [0:0]  s_data;
  logic [31:0] s_cnt;

  logic        b_en, b_load, b_mode, b_ready;
  logic        b_valid, b_wrap, b_lock;
  logic [15:0] b_seed;
  logic [7:0]  b_data;
  logic [31:0] b_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  lfsr_prng_stream #(
    .WIDTH (4),
    .TAPS  (4'hC),
    .SEED  (1),
    .OUT_W (1),
    .CNT_W (32)
  ) u_small (
    .clk        (clk),
    .preset_n   (rst_n),
    .en         (s_en),
    .load       (s_load),
    .seed_in    (s_seed),
    .mode_in    (s_mode),
    .out_data   (s_data),
    .out_valid  (s_valid),
    .out_ready  (s_ready),
    .word_cnt   (s_cnt),
    .wrap       (s_wrap),
    .lockup_err (s_lock)
  );

  lfsr_prng_stream u_big (
    .clk        (clk),
    .preset_n   (rst_n),
    .en         (b_en),
    .load       (b_load),
    .seed_in    (b_seed),
    .mode_in    (b_mode),
    .out_data   (b_data),
    .out_valid  (b_valid),
    .out_ready  (b_ready),
    .word_cnt   (b_cnt),
    .wrap       (b_wrap),
    .lockup_err (b_lock)
  );

  // x^4+x^3+1 state sequences starting from 1.
  logic [3:0] gal_tbl [16] = '{
    4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
    4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};
  logic [3:0] fib_tbl [16] = '{
    4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
    4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: Fibonacci shifts left and appends the
  // parity of tapped bits; Galois shifts right and
  // folds the taps in when a one falls out.
  function automatic logic [63:0] ref_step(
    input logic [63:0] s,
    input logic [63:0] taps,
    input int          w,
    input bit          gal
  );
    int          ones;
    logic [63:0] lim;
    lim = 64'd1 << w;
    if (gal) return (s >> 1) ^ (s[0] ? taps : 64'd0);
    ones = 0;
    for (int i = 0; i < w; i++)
      if (s[i] && taps[i]) ones++;
    return (s * 2 + 64'(ones % 2)) % lim;
  endfunction

  function automatic logic [63:0] ref_word(
    input logic [63:0] s,
    input bit          gal
  );
    logic [63:0] r;
    r = s;
    for (int k = 0; k < 8; k++)
      r = ref_step(r, 64'hB400, 16, gal);
    return r;
  endfunction

  logic [63:0] m_state, m_ref;
  bit          m_gal, m_valid, m_wrap, hs;
  int          m_cnt, cyc;
  logic [15:0] rseed;

  initial begin
    rst_n   = 1'b0;
    s_en    = 0; s_load = 0; s_mode = 0;
    s_ready = 0; s_seed = '0;
    b_en    = 0; b_load = 0; b_mode = 0;
    b_ready = 0; b_seed = '0;
    #12 rst_n = 1'b1;
    tick();

    chk("rst_s_valid", s_valid, 0);
    chk("rst_s_data", s_data, 1);
    chk("rst_s_cnt", s_cnt, 0);
    chk("rst_s_wrap", s_wrap, 0);
    chk("rst_s_lock", s_lock, 0);
    chk("rst_b_data", b_data, 8'h01);
    chk("rst_b_valid", b_valid, 0);

    // Galois full period from reset defaults.
    s_en = 1; s_ready = 1;
    tick();
    chk("gal_valid", s_valid, 1);
    chk("gal_d0", s_data, gal_tbl[0][0]);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("gal_data", s_data, gal_tbl[i][0]);
      chk("gal_cnt", s_cnt, i);
      chk("gal_wrap", s_wrap, i == 15);
    end
    s_ready = 0;
    tick();
    chk("gal_wrap_end", s_wrap, 0);
    chk("gal_cnt_hold", s_cnt, 15);

    // Fibonacci full period after load.
    s_load = 1; s_seed = 4'h1; s_mode = 0;
    tick();
    s_load = 0;
    chk("fib_cnt_clr", s_cnt, 0);
    chk("fib_valid", s_valid, 1);
    chk("fib_lock", s_lock, 0);
    s_ready = 1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("fib_data", s_data, fib_tbl[i][0]);
      chk("fib_cnt", s_cnt, i);
      chk("fib_wrap", s_wrap, i == 15);
    end
    s_ready = 0;

    // Backpressure with en dropped mid-stall.
    for (int c = 0; c < 5; c++) begin
      if (c == 2) s_en = 0;
      tick();
      chk("bp_valid", s_valid, 1);
      chk("bp_data", s_data, fib_tbl[0][0]);
      chk("bp_cnt", s_cnt, 15);
    end
    s_ready = 1;
    tick();
    chk("bp_hs_valid", s_valid, 0);
    chk("bp_hs_cnt", s_cnt, 16);
    chk("bp_hs_data", s_data, fib_tbl[1][0]);
    s_ready = 0;
    tick();
    chk("bp_idle", s_valid, 0);

    // Zero seed on the small instance.
    s_load = 1; s_seed = 4'h0; s_mode = 1;
    tick();
    s_load = 0;
    chk("s_lock_on", s_lock, 1);
    chk("s_lock_cnt", s_cnt, 0);
    chk("s_lock_data", s_data, 1);
    s_en = 1; s_ready = 1;
    tick();
    chk("s_lock_off", s_lock, 0);
    chk("s_lock_run", s_valid, 1);
    tick();
    chk("s_lock_next", s_data, gal_tbl[1][0]);
    s_ready = 0; s_en = 0;

    // Zero seed on the wide instance.
    b_load = 1; b_seed = 16'h0; b_mode = 0;
    tick();
    b_load = 0;
    chk("b_lock_on", b_lock, 1);
    chk("b_lock_data", b_data, 8'h01);
    tick();
    chk("b_lock_off", b_lock, 0);
    b_en = 1;
    tick();
    chk("b_run_valid", b_valid, 1);
    chk("b_run_data", b_data, 8'h01);
    b_ready = 1;
    tick();
    chk("b_fib_w1", b_data, ref_word(1, 0) & 64'hFF);
    chk("b_fib_cnt", b_cnt, 1);

    // Load coincident with a handshake.
    b_load = 1; b_seed = 16'hA5C3; b_mode = 1;
    tick();
    b_load = 0;
    chk("ldhs_data", b_data, 8'hC3);
    chk("ldhs_cnt", b_cnt, 0);
    chk("ldhs_valid", b_valid, 1);
    tick();
    chk("ldhs_next", b_data,
        ref_word(64'hA5C3, 1) & 64'hFF);
    chk("ldhs_cnt1", b_cnt, 1);
    b_ready = 0;

    // Randomised stream against the model.
    rseed = 16'($urandom_range(1, 16'hFFFF));
    b_load = 1; b_seed = rseed;
    b_mode = 1'($urandom_range(0, 1));
    m_gal  = b_mode;
    tick();
    b_load  = 0;
    m_state = 64'(rseed);
    m_ref   = m_state;
    m_valid = 1; m_cnt = 0; m_wrap = 0;
    cyc = 0;
    while (m_cnt < 1000 && cyc < 20000) begin
      chk("rnd_valid", b_valid, m_valid);
      if (m_valid)
        chk("rnd_data", b_data, m_state & 64'hFF);
      chk("rnd_cnt", b_cnt, m_cnt);
      chk("rnd_wrap", b_wrap, m_wrap);
      b_en    = ($urandom_range(0, 7) != 0);
      b_ready = ($urandom_range(0, 3) != 0);
      hs      = m_valid && b_ready;
      m_wrap  = 0;
      if (hs) begin
        m_state = ref_word(m_state, m_gal);
        m_cnt++;
        m_wrap = (m_state == m_ref);
      end
      m_valid = m_valid ? !(hs && !b_en) : b_en;
      tick();
      cyc++;
    end
    chk("rnd_budget", m_cnt >= 1000, 1);
    chk("rnd_cnt_end", b_cnt, 1000);
    chk("rnd_valid_end", b_valid, m_valid);
    if (m_valid)
      chk("rnd_data_end", b_data, m_state & 64'hFF);

    // Asynchronous reset with a word pending.
    b_en = 1; b_ready = 0;
    tick();
    chk("ar_pre_valid", b_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", b_valid, 0);
    chk("ar_data", b_data, 8'h01);
    chk("ar_cnt", b_cnt, 0);
    chk("ar_wrap", b_wrap, 0);
    chk("ar_lock", b_lock, 0);
    #3 rst_n = 1'b1;
    tick();
    chk("ar_rel_valid", b_valid, 1);
    chk("ar_rel_data", b_data, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
